// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between two writeback
//   requesters, A (ALU result) and B (load data), using round-robin priority.
//   The granted request is registered onto the write port one cycle later.
//   Writes to ZERO_REG complete their handshake but never raise wr_en, and
//   each one is tallied in a saturating drop counter.
//
// Ports
//   clk, reset               system clock, synchronous active-high reset
//   en                       global enable; no grants while low
//   a_valid/a_addr/a_data    requester A write request
//   a_ready                  A accepted this cycle (combinational)
//   b_valid/b_addr/b_data    requester B write request
//   b_ready                  B accepted this cycle (combinational)
//   wr_en/wr_addr/wr_data    registered register-file write port
//   wr_src                   source of the registered write (0 = A, 1 = B)
//   drop_cnt                 saturating count of discarded ZERO_REG writes
//
// State table
//   PRI_A | A wins when both requesters are valid
//   PRI_B | B wins when both requesters are valid

module regfile_write_arbiter #(
  parameter int          DATA_W   = 64,
  parameter int          ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  output logic [7:0]        drop_cnt
);

  typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

  pri_t              state;
  pri_t              state_next;
  logic              xfer;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              g_is_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PRI_A;
    end else begin
      state <= state_next;
    end
  end

  // Ready is gated by reset so a request presented during reset is held
  // off and granted once reset releases.
  always_comb begin
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    state_next = state;
    if (!reset && en) begin
      if (a_valid && b_valid) begin
        if (state == PRI_A) begin
          a_ready = 1'b1;
        end else begin
          b_ready = 1'b1;
        end
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
    // Priority always points at the requester that was not just served.
    if (a_ready) begin
      state_next = PRI_B;
    end else if (b_ready) begin
      state_next = PRI_A;
    end
  end

  assign xfer      = a_ready | b_ready;
  assign g_addr    = b_ready ? b_addr : a_addr;
  assign g_data    = b_ready ? b_data : a_data;
  assign g_is_zero = (g_addr == ADDR_W'(ZERO_REG));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_src   <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      wr_en <= xfer && !g_is_zero;
      // Address, data and source hold when idle; only the strobe clears.
      if (xfer) begin
        wr_addr <= g_addr;
        wr_data <= g_data;
        wr_src  <= b_ready;
      end
      if (xfer && g_is_zero && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        wr_src;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] rf [32];

  regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_src   (wr_src),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'd0;
    reset = 1'b1; en = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    step();
    step();

    // Reset state, and ready held off while reset is high.
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h1111;
    #1;
    chk("rst_a_ready", a_ready, 0);

    // A only after reset.
    reset = 1'b0;
    #1;
    chk("a_only_a_ready", a_ready, 1);
    chk("a_only_b_ready", b_ready, 0);
    step();
    a_valid = 1'b0;
    chk("a_only_wr_en", wr_en, 1);
    chk("a_only_wr_addr", wr_addr, 3);
    chk("a_only_wr_data", wr_data, 64'h1111);
    chk("a_only_wr_src", wr_src, 0);
    step();
    chk("idle_wr_en", wr_en, 0);
    chk("idle_wr_addr_hold", wr_addr, 3);
    chk("idle_wr_data_hold", wr_data, 64'h1111);

    // Both valid: alternating grants A, B, A, B.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_a_ready%0d", i), a_ready, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_b_ready%0d", i), b_ready, (i % 2 == 1) ? 1 : 0);
      step();
      chk($sformatf("rr_wr_en%0d", i), wr_en, 1);
      chk($sformatf("rr_wr_addr%0d", i), wr_addr, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("rr_wr_src%0d", i), wr_src, (i % 2 == 0) ? 0 : 1);
    end

    // en low for 3 cycles with both valid: no grants, priority holds at A.
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("en0_a_ready%0d", i), a_ready, 0);
      chk($sformatf("en0_b_ready%0d", i), b_ready, 0);
      step();
      chk($sformatf("en0_wr_en%0d", i), wr_en, 0);
    end
    en = 1'b1;
    #1;
    chk("en1_a_ready", a_ready, 1);
    chk("en1_b_ready", b_ready, 0);
    step();
    chk("en1_wr_src", wr_src, 0);
    #1;
    chk("en1_next_b_ready", b_ready, 1);
    a_valid = 1'b0; b_valid = 1'b0;
    step();

    // ZERO_REG writes from B: handshake completes, no strobe, counter saturates.
    do_reset();
    b_valid = 1'b1; b_addr = 5'd31; b_data = 64'hFFFF;
    #1;
    chk("zr_b_ready", b_ready, 1);
    step();
    chk("zr_wr_en", wr_en, 0);
    chk("zr_wr_addr", wr_addr, 31);
    chk("zr_wr_data", wr_data, 64'hFFFF);
    chk("zr_wr_src", wr_src, 1);
    chk("zr_drop1", drop_cnt, 1);
    for (int i = 2; i <= 300; i++) begin
      step();
      if (i == 100) chk("zr_drop100", drop_cnt, 100);
      if (i == 255) chk("zr_drop255", drop_cnt, 255);
    end
    chk("zr_drop_sat", drop_cnt, 255);
    chk("zr_wr_en_end", wr_en, 0);
    b_valid = 1'b0;
    step();

    // Reset the cycle after an A grant with B still pending.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 64'h66;
    #1;
    chk("mr_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_b_ready_in_rst", b_ready, 0);
    chk("mr_prior_wr_en", wr_en, 1);
    chk("mr_prior_wr_addr", wr_addr, 5);
    step();
    chk("mr_rst_wr_en", wr_en, 0);
    chk("mr_rst_wr_addr", wr_addr, 0);
    chk("mr_rst_b_ready", b_ready, 0);
    reset = 1'b0;
    #1;
    chk("mr_rel_b_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("mr_rel_wr_en", wr_en, 1);
    chk("mr_rel_wr_addr", wr_addr, 6);
    chk("mr_rel_wr_src", wr_src, 1);

    // Same address from both requesters: A then B, B's data is final.
    do_reset();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'hAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hBB;
    #1;
    chk("sa_a_ready", a_ready, 1);
    step();
    a_valid = 1'b0;
    chk("sa_first_data", wr_data, 64'hAA);
    #1;
    chk("sa_b_ready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("sa_second_data", wr_data, 64'hBB);
    chk("sa_second_wr_en", wr_en, 1);
    step();
    chk("sa_rf7", rf[7], 64'hBB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
